// File: rtl/cache_block_transfer.sv
// -----------------------------------------------------------------------------
// cache_block_transfer
//
// Moves one cache block at a time between the memory-side bus and a single
// data cache bank.
//   * Refill:    accepts a word stream from memory (valid/ready) and writes
//                each word into the bank, one bank write per accepted beat.
//   * Writeback: reads the victim block through the bank read port (1-cycle
//                read latency) and streams it out under valid/ready
//                backpressure through a 2-entry output buffer.
// Word address inside the bank is {block index, word offset}.
//
// Ports
//   clk_i                 clock, everything on the rising edge
//   rst_i                 synchronous reset, active-high
//   start_refill_i        request refill of block_address_i (IDLE only)
//   start_writeback_i     request writeback of block_address_i (IDLE only,
//                         wins over a simultaneous refill request)
//   block_address_i       block index, captured when a start is accepted
//   busy_o                transfer in progress (registered)
//   done_o                one-cycle pulse the cycle after a transfer ends
//   refill_data_i         incoming refill word
//   refill_valid_i        refill word valid
//   refill_ready_o        engine accepts a refill word (high in REFILL)
//   wb_data_o             outgoing writeback word (head of output buffer)
//   wb_valid_o            writeback word valid
//   wb_ready_i            downstream accepts the writeback word
//   wb_last_o             current writeback word is the last of the block
//   bank_write_o          bank write enable
//   bank_byte_write_o     bank byte enables
//   bank_write_address_o  bank write word address
//   bank_write_data_o     bank write data
//   bank_read_o           bank read enable
//   bank_read_address_o   bank read word address
//   bank_read_data_i      bank read data, valid one cycle after bank_read_o
// -----------------------------------------------------------------------------
module cache_block_transfer #(
  parameter int ADDR_WIDTH  = 9,
  parameter int BLOCK_WORDS = 4,
  localparam int OFFSET     = $clog2(BLOCK_WORDS),
  localparam int BLK_W      = ADDR_WIDTH - OFFSET
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_refill_i,
  input  logic                  start_writeback_i,
  input  logic [BLK_W-1:0]      block_address_i,
  output logic                  busy_o,
  output logic                  done_o,
  input  logic [31:0]           refill_data_i,
  input  logic                  refill_valid_i,
  output logic                  refill_ready_o,
  output logic [31:0]           wb_data_o,
  output logic                  wb_valid_o,
  input  logic                  wb_ready_i,
  output logic                  wb_last_o,
  output logic                  bank_write_o,
  output logic [3:0]            bank_byte_write_o,
  output logic [ADDR_WIDTH-1:0] bank_write_address_o,
  output logic [31:0]           bank_write_data_o,
  output logic                  bank_read_o,
  output logic [ADDR_WIDTH-1:0] bank_read_address_o,
  input  logic [31:0]           bank_read_data_i
);

  localparam logic [OFFSET:0]   BW_CNT   = (OFFSET+1)'(BLOCK_WORDS);
  localparam logic [OFFSET:0]   LAST_CNT = (OFFSET+1)'(BLOCK_WORDS - 1);
  localparam logic [OFFSET-1:0] LAST_OFF = OFFSET'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_REFILL    = 2'd1,
    ST_WRITEBACK = 2'd2
  } state_t;

  // Control state
  state_t            state_q;
  logic              busy_q;
  logic              done_q;
  logic [BLK_W-1:0]  block_q;
  logic [OFFSET-1:0] wcnt_q;     // next refill word offset
  logic [OFFSET:0]   rcnt_q;     // next writeback read offset
  logic [OFFSET:0]   pcnt_q;     // offset of the word at the buffer head
  logic [1:0]        occ_q;      // words stored in the output buffer
  logic              wr_ptr_q;
  logic              rd_ptr_q;

  // Stage p1: bank read returning this cycle, and the buffered words
  logic              rd_vld_p1;
  logic [31:0]       buf_p1 [2];

  logic              refill_beat;
  logic              wb_active;
  logic              wb_valid;
  logic              wb_pop;
  logic [31:0]       wb_head;
  logic [2:0]        pending;
  logic              rd_issue;

  assign refill_beat = (state_q == ST_REFILL) && refill_valid_i;
  assign wb_active   = (state_q == ST_WRITEBACK);

  // A word returning from the bank counts as present in the buffer in the
  // cycle it arrives: it is presented straight from the read data when the
  // stored part of the buffer is empty. This is what gives one word per
  // cycle right after the first read.
  assign wb_valid = wb_active && ((occ_q != 2'd0) || rd_vld_p1);
  assign wb_pop   = wb_valid && wb_ready_i;
  assign wb_head  = (occ_q == 2'd0) ? bank_read_data_i : buf_p1[rd_ptr_q];

  // Words that will be held after this cycle (stored + arriving - leaving).
  // Issuing only while this is below 2 means the read data returning next
  // cycle always has a free entry.
  assign pending  = {1'b0, occ_q} + {2'b00, rd_vld_p1} - {2'b00, wb_pop};
  assign rd_issue = wb_active && (rcnt_q < BW_CNT) && (pending < 3'd2);

  // Data/address outputs are forced to zero whenever their strobe is low so
  // that nothing is visible on the ports outside an active beat.
  assign refill_ready_o       = (state_q == ST_REFILL);
  assign bank_write_o         = refill_beat;
  assign bank_byte_write_o    = refill_beat ? 4'hF : 4'h0;
  assign bank_write_address_o = refill_beat ? {block_q, wcnt_q} : '0;
  assign bank_write_data_o    = refill_beat ? refill_data_i : '0;

  assign bank_read_o          = rd_issue;
  assign bank_read_address_o  = rd_issue ? {block_q, rcnt_q[OFFSET-1:0]} : '0;

  assign wb_valid_o           = wb_valid;
  assign wb_data_o            = wb_valid ? wb_head : '0;
  assign wb_last_o            = wb_valid && (pcnt_q == LAST_CNT);

  assign busy_o               = busy_q;
  assign done_o               = done_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      block_q   <= '0;
      wcnt_q    <= '0;
      rcnt_q    <= '0;
      pcnt_q    <= '0;
      occ_q     <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rd_vld_p1 <= 1'b0;
      for (int i = 0; i < 2; i++) buf_p1[i] <= '0;
    end else begin
      done_q    <= 1'b0;
      rd_vld_p1 <= rd_issue;

      case (state_q)
        ST_IDLE: begin
          // Writeback has priority: the caller evicts before it refills.
          if (start_writeback_i) begin
            state_q  <= ST_WRITEBACK;
            busy_q   <= 1'b1;
            block_q  <= block_address_i;
            rcnt_q   <= '0;
            pcnt_q   <= '0;
            occ_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
          end else if (start_refill_i) begin
            state_q  <= ST_REFILL;
            busy_q   <= 1'b1;
            block_q  <= block_address_i;
            wcnt_q   <= '0;
          end
        end

        ST_REFILL: begin
          if (refill_beat) begin
            wcnt_q <= wcnt_q + 1'b1;
            if (wcnt_q == LAST_OFF) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end

        ST_WRITEBACK: begin
          // Every returning word is written at the tail; when it is also
          // popped in the same cycle both pointers advance and the stored
          // count is unchanged, so the bypass case needs no special path.
          if (rd_vld_p1) begin
            buf_p1[wr_ptr_q] <= bank_read_data_i;
            wr_ptr_q         <= ~wr_ptr_q;
          end
          if (rd_issue) rcnt_q <= rcnt_q + 1'b1;
          if (wb_pop) begin
            rd_ptr_q <= ~rd_ptr_q;
            pcnt_q   <= pcnt_q + 1'b1;
          end
          occ_q <= pending[1:0];
          if (wb_pop && (pcnt_q == LAST_CNT)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cache_block_transfer.sv
module tb_cache_block_transfer;

  localparam int AW = 9;
  localparam int BW = 4;
  localparam int BLKW = AW - $clog2(BW);

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_refill_i;
  logic            start_writeback_i;
  logic [BLKW-1:0] block_address_i;
  logic            busy_o;
  logic            done_o;
  logic [31:0]     refill_data_i;
  logic            refill_valid_i;
  logic            refill_ready_o;
  logic [31:0]     wb_data_o;
  logic            wb_valid_o;
  logic            wb_ready_i;
  logic            wb_last_o;
  logic            bank_write_o;
  logic [3:0]      bank_byte_write_o;
  logic [AW-1:0]   bank_write_address_o;
  logic [31:0]     bank_write_data_o;
  logic            bank_read_o;
  logic [AW-1:0]   bank_read_address_o;
  logic [31:0]     bank_read_data_i = '0;

  cache_block_transfer #(.ADDR_WIDTH(AW), .BLOCK_WORDS(BW)) dut (
    .clk_i                (clk_i),
    .rst_i                (rst_i),
    .start_refill_i       (start_refill_i),
    .start_writeback_i    (start_writeback_i),
    .block_address_i      (block_address_i),
    .busy_o               (busy_o),
    .done_o               (done_o),
    .refill_data_i        (refill_data_i),
    .refill_valid_i       (refill_valid_i),
    .refill_ready_o       (refill_ready_o),
    .wb_data_o            (wb_data_o),
    .wb_valid_o           (wb_valid_o),
    .wb_ready_i           (wb_ready_i),
    .wb_last_o            (wb_last_o),
    .bank_write_o         (bank_write_o),
    .bank_byte_write_o    (bank_byte_write_o),
    .bank_write_address_o (bank_write_address_o),
    .bank_write_data_o    (bank_write_data_o),
    .bank_read_o          (bank_read_o),
    .bank_read_address_o  (bank_read_address_o),
    .bank_read_data_i     (bank_read_data_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk_i) cyc <= cyc + 1;

  // Bank model: word array, write applied at the edge, read data one cycle later.
  logic [31:0] mem [0:(1<<AW)-1];
  always @(posedge clk_i) begin
    if (bank_write_o) mem[bank_write_address_o] <= bank_write_data_o;
    if (bank_read_o)  bank_read_data_i <= mem[bank_read_address_o];
  end

  // Observed events
  int          wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  int          wr_cyc_q[$];
  int          rd_addr_q[$];
  int          rd_cyc_q[$];
  logic [31:0] pop_data_q[$];
  logic        pop_last_q[$];
  int          pop_cyc_q[$];
  int          done_cyc_q[$];
  int          first_valid;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    rd_addr_q.delete(); rd_cyc_q.delete();
    pop_data_q.delete(); pop_last_q.delete(); pop_cyc_q.delete();
    done_cyc_q.delete();
    first_valid = -1;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_done"},  done_o, 0);
    check({tag, "_rrdy"},  refill_ready_o, 0);
    check({tag, "_wbv"},   wb_valid_o, 0);
    check({tag, "_wbd"},   wb_data_o, 0);
    check({tag, "_wbl"},   wb_last_o, 0);
    check({tag, "_bw"},    bank_write_o, 0);
    check({tag, "_bbw"},   bank_byte_write_o, 0);
    check({tag, "_bwa"},   bank_write_address_o, 0);
    check({tag, "_bwd"},   bank_write_data_o, 0);
    check({tag, "_br"},    bank_read_o, 0);
    check({tag, "_bra"},   bank_read_address_o, 0);
  endtask

  // Per-cycle monitor, sampled mid-cycle
  initial begin
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        check("port_excl", bank_write_o & bank_read_o, 0);
        if (busy_o) check("occ_le2", (rd_addr_q.size() - pop_data_q.size()) <= 2, 1);
        if (prev_stall) begin
          check("stall_valid", wb_valid_o, 1);
          check("stall_data", wb_data_o, prev_data);
        end
        if (bank_write_o) begin
          check("byte_en", bank_byte_write_o, 4'hF);
          wr_addr_q.push_back(int'(bank_write_address_o));
          wr_data_q.push_back(bank_write_data_o);
          wr_cyc_q.push_back(cyc);
        end
        if (bank_read_o) begin
          rd_addr_q.push_back(int'(bank_read_address_o));
          rd_cyc_q.push_back(cyc);
        end
        if (wb_valid_o && first_valid < 0) first_valid = cyc;
        if (wb_valid_o && wb_ready_i) begin
          pop_data_q.push_back(wb_data_o);
          pop_last_q.push_back(wb_last_o);
          pop_cyc_q.push_back(cyc);
        end
        if (done_o) done_cyc_q.push_back(cyc);
      end
      prev_stall = wb_valid_o && !wb_ready_i && !rst_i;
      prev_data  = wb_data_o;
    end
  end

  // mode 0: valid always 1, mode 1: fixed gap pattern, mode 2: random
  task automatic do_refill(input int blk, input int mode, input string tag);
    logic [31:0] words[$];
    int pat[7] = '{1, 0, 0, 1, 1, 0, 1};
    int nv = 0;
    int k = 0;
    logic v;
    clear_mon();
    block_address_i = BLKW'(blk);
    start_refill_i  = 1'b1;
    step();
    start_refill_i  = 1'b0;
    check({tag, "_busy_on"}, busy_o, 1);
    while (nv < BW && k < 64) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 7][0] : 1'($urandom_range(0, 1));
      refill_valid_i = v;
      refill_data_i  = $urandom;
      if (v) begin
        words.push_back(refill_data_i);
        nv++;
      end
      step();
      k++;
    end
    refill_valid_i = 1'b0;
    for (int i = 0; i < 20 && done_cyc_q.size() == 0; i++) step();
    repeat (3) step();
    check({tag, "_nwr"}, wr_addr_q.size(), BW);
    check({tag, "_ndone"}, done_cyc_q.size(), 1);
    check({tag, "_busy_off"}, busy_o, 0);
    if (wr_addr_q.size() == BW) begin
      for (int i = 0; i < BW; i++) begin
        check({tag, "_waddr"}, wr_addr_q[i], blk * BW + i);
        check({tag, "_wdata"}, wr_data_q[i], words[i]);
        if (mode == 0) check({tag, "_wcyc"}, wr_cyc_q[i], wr_cyc_q[0] + i);
      end
      if (done_cyc_q.size() == 1)
        check({tag, "_done_cyc"}, done_cyc_q[0], wr_cyc_q[BW-1] + 1);
    end
  endtask

  // mode 0: ready always 1, mode 1: fixed toggle pattern, mode 2: random
  task automatic do_wb(input int blk, input int mode, input bit both_start,
                       input bit busy_starts, input string tag);
    logic [31:0] words[$];
    int pat[7] = '{1, 0, 0, 1, 0, 1, 1};
    int k = 0;
    for (int i = 0; i < BW; i++) begin
      words.push_back($urandom);
      mem[blk * BW + i] <= words[i];
    end
    @(posedge clk_i);
    #1;
    clear_mon();
    block_address_i   = BLKW'(blk);
    start_writeback_i = 1'b1;
    start_refill_i    = both_start;
    step();
    start_writeback_i = 1'b0;
    start_refill_i    = 1'b0;
    check({tag, "_busy_on"}, busy_o, 1);
    while (done_cyc_q.size() == 0 && k < 100) begin
      wb_ready_i = (mode == 0) ? 1'b1 : (mode == 1) ? pat[k % 7][0] : 1'($urandom_range(0, 1));
      refill_valid_i = both_start;
      refill_data_i  = $urandom;
      if (busy_starts && k == 2) begin
        start_refill_i    = 1'b1;
        start_writeback_i = 1'b1;
        block_address_i   = BLKW'(blk ^ 1);
      end
      step();
      start_refill_i    = 1'b0;
      start_writeback_i = 1'b0;
      k++;
    end
    refill_valid_i = 1'b0;
    wb_ready_i     = 1'b1;
    repeat (3) step();
    check({tag, "_npop"}, pop_data_q.size(), BW);
    check({tag, "_nrd"}, rd_addr_q.size(), BW);
    check({tag, "_nwr"}, wr_addr_q.size(), 0);
    check({tag, "_ndone"}, done_cyc_q.size(), 1);
    check({tag, "_busy_off"}, busy_o, 0);
    check({tag, "_idle_rrdy"}, refill_ready_o, 0);
    if (pop_data_q.size() == BW && rd_addr_q.size() == BW) begin
      for (int i = 0; i < BW; i++) begin
        check({tag, "_data"}, pop_data_q[i], words[i]);
        check({tag, "_last"}, pop_last_q[i], (i == BW - 1));
        check({tag, "_raddr"}, rd_addr_q[i], blk * BW + i);
        if (mode == 0) check({tag, "_pcyc"}, pop_cyc_q[i], rd_cyc_q[0] + 1 + i);
      end
      if (mode == 0) check({tag, "_first_valid"}, first_valid, rd_cyc_q[0] + 1);
      if (done_cyc_q.size() == 1)
        check({tag, "_done_cyc"}, done_cyc_q[0], pop_cyc_q[BW-1] + 1);
    end
  endtask

  initial begin
    rst_i             = 1'b1;
    start_refill_i    = 1'b0;
    start_writeback_i = 1'b0;
    block_address_i   = '0;
    refill_data_i     = '0;
    refill_valid_i    = 1'b0;
    wb_ready_i        = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    clear_mon();
    repeat (3) step();
    check_all_zero("reset");
    rst_i = 1'b0;
    step();

    // Refill, back-to-back words, then with gaps
    do_refill(5, 0, "rf_full");
    do_refill(9, 1, "rf_gaps");

    // Writeback at full rate, then under backpressure
    do_wb(2, 0, 1'b0, 1'b0, "wb_full");
    do_wb(6, 1, 1'b0, 1'b0, "wb_stall");

    // Simultaneous starts, and starts while busy
    do_wb(11, 2, 1'b1, 1'b1, "wb_prio");

    // Reset in the middle of a writeback
    begin
      int k = 0;
      for (int i = 0; i < BW; i++) mem[3 * BW + i] <= $urandom;
      step();
      clear_mon();
      block_address_i   = BLKW'(3);
      start_writeback_i = 1'b1;
      wb_ready_i        = 1'b1;
      step();
      start_writeback_i = 1'b0;
      while (pop_data_q.size() < 2 && k < 20) begin
        step();
        k++;
      end
      check("rst_mid_two_beats", pop_data_q.size(), 2);
      rst_i = 1'b1;
      step();
      rst_i = 1'b0;
      check_all_zero("rst_mid");
      repeat (4) step();
      check("rst_mid_no_done", done_cyc_q.size(), 0);
      check("rst_mid_idle", busy_o, 0);
    end
    do_refill(7, 2, "rf_after_rst");

    // Randomized transfers
    for (int r = 0; r < 4; r++) begin
      do_refill(int'($urandom_range(0, (1 << BLKW) - 1)), 2, "rf_rand");
      do_wb(int'($urandom_range(0, (1 << BLKW) - 1)), 2, 1'b0, 1'b0, "wb_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
